// File: rtl/ext_2p_mem_resp_pkg.sv
// Shared definitions for the two-port memory responder: clear FSM encoding
// and the default status counter width.
package ext_2p_mem_resp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/ext_2p_mem_resp_ram_core.sv
// 1W1R synchronous RAM, read-first, with a registered read-data output that
// only updates on read enable. The array itself is never reset.
module ext_2p_ram_core #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; non-blocking semantics give the pre-write word on a
    // same-address read+write, and the output holds when re is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ext_2p_mem_resp.sv
// Two-port memory responder: serves unit reads/writes, owns a clear engine
// that zeroes the whole array one word per cycle, and keeps collision and
// dropped-write counters.
//
// Access semantics: the unit port has no back-pressure. A read with
// ext_2p_read_0 high is always accepted and its data appears on
// ext_2p_data_in_0 one cycle later; a write with ext_2p_write_0 high is
// accepted unless clear_busy is high, in which case it is discarded and
// counted in drop_cnt.
module ext_2p_mem_resp
    import ext_2p_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_2p_write_0,
    input  logic [ADDR_W-1:0] ext_2p_addr_out_0,
    input  logic [DATA_W-1:0] ext_2p_data_out_0,
    input  logic              ext_2p_read_0,
    input  logic [ADDR_W-1:0] ext_2p_addr_in_0,
    output logic [DATA_W-1:0] ext_2p_data_in_0,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [CNT_W-1:0]  collision_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output clr_state_t        dbg_state
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    // One extra bit so the terminal compare never depends on wrap-around.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W:0]   clr_addr, clr_addr_nxt;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              unit_wr_ok;
    logic              collision;
    logic              dropped;

    assign clear_busy = (state == ST_CLEAR);
    assign dbg_state  = state;

    // Clear FSM next-state and address counter.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_IDLE: begin
                if (clear_start) begin
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            ST_CLEAR: begin
                // clear_start is deliberately ignored here: no restart.
                if (clr_addr == LAST_ADDR) begin
                    state_nxt    = ST_IDLE;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + (ADDR_W+1)'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                clr_addr_nxt = '0;
            end
        endcase
    end

    // Clear FSM state register; reset aborts a clear in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // Write-port mux: the clear engine owns the port while busy; reset
    // blocks every write in its cycle.
    always_comb begin
        unit_wr_ok = ext_2p_write_0 && !clear_busy;
        ram_we     = !rst && (clear_busy || ext_2p_write_0);
        ram_waddr  = clear_busy ? clr_addr[ADDR_W-1:0] : ext_2p_addr_out_0;
        ram_wdata  = clear_busy ? '0 : ext_2p_data_out_0;
        // Only unit-write collisions count; clear-engine overlaps do not.
        collision  = unit_wr_ok && ext_2p_read_0 &&
                     (ext_2p_addr_out_0 == ext_2p_addr_in_0);
        dropped    = ext_2p_write_0 && clear_busy;
    end

    // Saturating status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            if (collision && (collision_cnt != '1)) begin
                collision_cnt <= collision_cnt + CNT_W'(1);
            end
            if (dropped && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    ext_2p_ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ext_2p_read_0),
        .raddr (ext_2p_addr_in_0),
        .rdata (ext_2p_data_in_0)
    );

endmodule
